// File: rtl/keypad_evt_if.sv
// keypad_evt_if: key-event stream from keypad_event_queue to its consumer.
//   evt_valid/evt_ready - show-ahead handshake, head pops when both high
//   evt_kind            - 0 INSERT, 1 DEL, 2 LEFT, 3 RIGHT, 4 EVAL
//   evt_repeat          - event produced by auto-repeat
//   evt_code            - key code for INSERT, zero otherwise
//   fifo_count          - occupied queue entries
//   overflow            - sticky flag: an event was dropped on a full queue
interface keypad_evt_if #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  logic             evt_valid;
  logic             evt_ready;
  logic [2:0]       evt_kind;
  logic             evt_repeat;
  logic [WIDTH-1:0] evt_code;
  logic [CNTW-1:0]  fifo_count;
  logic             overflow;

  modport master (
    output evt_valid,
    input  evt_ready,
    output evt_kind,
    output evt_repeat,
    output evt_code,
    output fifo_count,
    output overflow
  );

  modport slave (
    input  evt_valid,
    output evt_ready,
    input  evt_kind,
    input  evt_repeat,
    input  evt_code,
    input  fifo_count,
    input  overflow
  );
endinterface

// File: rtl/keypad_event_queue.sv
// keypad_event_queue: calculator key front-end. Synchronises and debounces
// BUTTONS symbol buttons plus del/ptr_left/ptr_right/eval, turns debounced
// press edges into key events (with auto-repeat on the held key) and queues
// them in a show-ahead FIFO.
//   clock, reset            - system clock, synchronous active-high reset
//   b, del, ptr_left,
//   ptr_right, eval         - raw asynchronous active-high buttons
//   evt (master modport)    - event stream and queue status
module keypad_event_queue #(
  parameter int WIDTH           = 8,
  parameter int BUTTONS         = 32,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [BUTTONS-1:0] b,
  input  logic               del,
  input  logic               ptr_left,
  input  logic               ptr_right,
  input  logic               eval,
  keypad_evt_if.master       evt
);
  localparam int CH   = BUTTONS + 4;
  localparam int CIW  = $clog2(CH);
  localparam int DCW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [DCW-1:0] DEB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);
  localparam logic [CIW-1:0] EVAL_CH     = CIW'(CH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT, ST_HOLD} state_t;

  // INSERT key-code table for symbol button index idx.
  function automatic logic [7:0] insert_code(input logic [CIW-1:0] idx);
    logic [7:0] v;
    v = 8'(idx);
    if (v <= 8'd9)       return v;
    else if (v <= 8'd15) return v + 8'h10;   // 10..15 -> 0x1A..0x1F
    else if (v == 8'd16) return 8'hDD;
    else if (v <= 8'd18) return v + 8'hAF;   // 17,18 -> 0xC0,0xC1
    else                 return v + 8'hDD;   // 19..31 -> 0xF0..0xFC
  endfunction

  // Event kind for a channel: symbol buttons first, then del/left/right/eval.
  function automatic logic [2:0] chan_kind(input logic [CIW-1:0] ch);
    if (int'(ch) < BUTTONS) return 3'd0;
    else                    return 3'(int'(ch) - BUTTONS + 1);
  endfunction

  logic [CH-1:0]  raw_s;
  logic [CH-1:0]  sync1_q, sync2_q;
  logic [1:0]     vld_q;
  logic [CH-1:0]  deb_q, deb_d, deb_prev_q;
  logic [DCW-1:0] deb_cnt_q [CH];
  logic [DCW-1:0] deb_cnt_d [CH];
  logic [CH-1:0]  armed_q, armed_d;
  logic [CH-1:0]  rise_s;
  logic           win_any_s;
  logic [CIW-1:0] win_idx_s;

  state_t         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [CIW-1:0] held_q, held_d;
  logic           push_s, push_rep_s;
  logic [CIW-1:0] push_ch_s;
  logic [2:0]     push_kind_s;
  logic [WIDTH-1:0] push_code_s;

  logic [2:0]       kind_mem_q [FIFO_DEPTH];
  logic             rep_mem_q  [FIFO_DEPTH];
  logic [WIDTH-1:0] code_mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q, count_d;
  logic             overflow_q;
  logic             full_s, valid_s, pop_s, wr_s;

  assign raw_s = {eval, ptr_right, ptr_left, del, b};

  // Two-flop synchronisers; vld_q marks when sync2_q reflects real inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // Debounce and arming. A channel arms once it has been seen released after
  // reset, so a key held through reset yields nothing until re-pressed.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    armed_d   = armed_q;
    for (int i = 0; i < CH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
      end
      armed_d[i] = armed_q[i] | (vld_q[1] & ~sync2_q[i] & ~deb_q[i]);
    end
  end

  // Debounced state, its previous value and the per-channel counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      armed_q    <= '0;
      for (int i = 0; i < CH; i++) deb_cnt_q[i] <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      armed_q    <= armed_d;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  assign rise_s = deb_q & ~deb_prev_q & armed_q;

  // Lowest-index rising channel wins; the other simultaneous edges are lost.
  always_comb begin
    win_any_s = |rise_s;
    win_idx_s = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      win_idx_s = rise_s[i] ? CIW'(i) : win_idx_s;
    end
  end

  // Repeat FSM: next state, repeat counter and event push request.
  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    held_d     = held_q;
    push_s     = 1'b0;
    push_rep_s = 1'b0;
    push_ch_s  = held_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any_s) begin
          push_s    = 1'b1;
          push_ch_s = win_idx_s;
          held_d    = win_idx_s;
          rcnt_d    = '0;
          if ((win_idx_s == EVAL_CH) || (REPEAT_DELAY == 0)) state_d = ST_HOLD;
          else                                               state_d = ST_DELAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        // Release takes priority over a repeat due in the same cycle.
        if (!deb_q[held_q]) begin
          state_d = ST_IDLE;
        end else if (rcnt_q == DELAY_LAST) begin
          push_s     = 1'b1;
          push_rep_s = 1'b1;
          rcnt_d     = '0;
          state_d    = ST_REPEAT;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      ST_REPEAT: begin
        if (!deb_q[held_q]) begin
          state_d = ST_IDLE;
        end else if (rcnt_q == PERIOD_LAST) begin
          push_s     = 1'b1;
          push_rep_s = 1'b1;
          rcnt_d     = '0;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      ST_HOLD: begin
        if (!deb_q[held_q]) state_d = ST_IDLE;
        else                state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Repeat FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      held_q  <= held_d;
    end
  end

  assign push_kind_s = chan_kind(push_ch_s);
  assign push_code_s = (push_kind_s == 3'd0) ? WIDTH'(insert_code(push_ch_s)) : '0;

  assign full_s  = (count_q == CNTW'(FIFO_DEPTH));
  assign valid_s = (count_q != '0);
  assign pop_s   = valid_s & evt.evt_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign wr_s    = push_s & (~full_s | pop_s);

  // Occupancy next value.
  always_comb begin
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue pointers, occupancy and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_s  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q    <= count_d;
      overflow_q <= overflow_q | (push_s & full_s & ~pop_s);
    end
  end

  // Queue storage; contents are only visible while evt_valid is high.
  always_ff @(posedge clock) begin
    if (wr_s) begin
      kind_mem_q[wr_ptr_q] <= push_kind_s;
      rep_mem_q[wr_ptr_q]  <= push_rep_s;
      code_mem_q[wr_ptr_q] <= push_code_s;
    end
  end

  assign evt.evt_valid  = valid_s;
  assign evt.evt_kind   = valid_s ? kind_mem_q[rd_ptr_q] : 3'd0;
  assign evt.evt_repeat = valid_s ? rep_mem_q[rd_ptr_q]  : 1'b0;
  assign evt.evt_code   = valid_s ? code_mem_q[rd_ptr_q] : '0;
  assign evt.fifo_count = count_q;
  assign evt.overflow   = overflow_q;
endmodule

// File: tb/tb_keypad_event_queue.sv
// Scoreboard bench for keypad_event_queue: stimulus pushes expected events
// (with expected delivery cycle, or -1 for don't-care) and a negedge monitor
// pops and compares on every evt_valid & evt_ready handshake.
module tb_keypad_event_queue;
  localparam int WIDTH = 8;
  localparam int BUTTONS = 32;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int FD = 4;
  localparam int LAT = DC + 3;  // drive at negedge cyc=C -> seen at cyc C+LAT

  logic clock = 1'b0;
  logic reset;
  logic [BUTTONS-1:0] b;
  logic del, ptr_left, ptr_right, eval;

  keypad_evt_if #(.WIDTH(WIDTH), .FIFO_DEPTH(FD)) evt_bus ();

  keypad_event_queue #(
    .WIDTH(WIDTH), .BUTTONS(BUTTONS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .reset(reset), .b(b), .del(del), .ptr_left(ptr_left),
    .ptr_right(ptr_right), .eval(eval), .evt(evt_bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;
    logic       rep;
    logic [7:0] code;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  // Monitor: compare every delivered event against the scoreboard head.
  always @(negedge clock) begin
    if (!reset && evt_bus.evt_valid && evt_bus.evt_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event kind=%0d rep=%0d code=%h cyc=%0d",
                 evt_bus.evt_kind, evt_bus.evt_repeat, evt_bus.evt_code, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (evt_bus.evt_kind !== mon_e.kind || evt_bus.evt_repeat !== mon_e.rep ||
            evt_bus.evt_code !== mon_e.code || (mon_e.at >= 0 && mon_e.at != cyc)) begin
          bad++;
          $display("FAIL event got kind=%0d rep=%0d code=%h cyc=%0d want kind=%0d rep=%0d code=%h cyc=%0d",
                   evt_bus.evt_kind, evt_bus.evt_repeat, evt_bus.evt_code, cyc,
                   mon_e.kind, mon_e.rep, mon_e.code, mon_e.at);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_evt(input logic [2:0] k, input logic r, input logic [7:0] c, input int at);
    exp_t x;
    x.kind = k;
    x.rep  = r;
    x.code = c;
    x.at   = at;
    sb.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, want);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
    check(name, sb.size(), 0);
  endtask

  task automatic tap(input int idx);
    b[idx] = 1'b1;
    tick(8);
    b[idx] = 1'b0;
    tick(10);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  int c0;
  int codes[5];

  initial begin
    reset = 1'b1;
    b = '0; del = 1'b0; ptr_left = 1'b0; ptr_right = 1'b0; eval = 1'b0;
    evt_bus.evt_ready = 1'b1;
    tick(5);
    check("rst_valid", int'(evt_bus.evt_valid), 0);
    check("rst_count", int'(evt_bus.fifo_count), 0);
    check("rst_overflow", int'(evt_bus.overflow), 0);
    check("rst_kind", int'(evt_bus.evt_kind), 0);
    check("rst_code", int'(evt_bus.evt_code), 0);
    check("rst_repeat", int'(evt_bus.evt_repeat), 0);
    reset = 1'b0;
    tick(5);

    // Clean press of b[3] held 40 cycles: press plus three repeats.
    c0 = cyc;
    b[3] = 1'b1;
    expect_evt(3'd0, 1'b0, 8'h03, c0 + LAT);
    expect_evt(3'd0, 1'b1, 8'h03, c0 + LAT + RD);
    expect_evt(3'd0, 1'b1, 8'h03, c0 + LAT + RD + RP);
    expect_evt(3'd0, 1'b1, 8'h03, c0 + LAT + RD + 2 * RP);
    tick(40);
    b[3] = 1'b0;
    tick(30);
    drain("drain_clean");

    // Bounce on b[12]: pairs of cycles high/low, stable high from c0+8.
    c0 = cyc;
    for (int k = 0; k < 10; k++) begin
      b[12] = ((k / 2) % 2 == 0);
      tick(1);
    end
    b[12] = 1'b1;
    expect_evt(3'd0, 1'b0, 8'h1C, c0 + 8 + LAT);
    tick(6);
    b[12] = 1'b0;
    tick(25);
    drain("drain_bounce");

    // del held 60 cycles: press then repeats until release.
    c0 = cyc;
    del = 1'b1;
    expect_evt(3'd1, 1'b0, 8'h00, c0 + LAT);
    for (int r = 0; r < 5; r++) expect_evt(3'd1, 1'b1, 8'h00, c0 + LAT + RD + r * RP);
    tick(60);
    del = 1'b0;
    tick(20);
    drain("drain_del");

    // eval held 60 cycles: single event, never repeats.
    c0 = cyc;
    eval = 1'b1;
    expect_evt(3'd4, 1'b0, 8'h00, c0 + LAT);
    tick(60);
    eval = 1'b0;
    tick(20);
    drain("drain_eval");

    // b[16] and ptr_left together: b[16] wins; ptr_left re-press ignored.
    c0 = cyc;
    b[16] = 1'b1;
    ptr_left = 1'b1;
    expect_evt(3'd0, 1'b0, 8'hDD, c0 + LAT);
    expect_evt(3'd0, 1'b1, 8'hDD, c0 + LAT + RD);
    tick(8);
    ptr_left = 1'b0;
    tick(8);
    ptr_left = 1'b1;
    tick(12);
    b[16] = 1'b0;
    tick(20);
    ptr_left = 1'b0;
    tick(20);
    drain("drain_simul");

    // Backpressure: five presses into a four-deep queue.
    evt_bus.evt_ready = 1'b0;
    codes[0] = 0; codes[1] = 9; codes[2] = 10; codes[3] = 13; codes[4] = 31;
    for (int p = 0; p < 5; p++) tap(codes[p]);
    check("bp_count", int'(evt_bus.fifo_count), 4);
    check("bp_overflow", int'(evt_bus.overflow), 1);
    check("bp_valid", int'(evt_bus.evt_valid), 1);
    check("bp_head_code", int'(evt_bus.evt_code), 8'h00);
    expect_evt(3'd0, 1'b0, 8'h00, -1);
    expect_evt(3'd0, 1'b0, 8'h09, -1);
    expect_evt(3'd0, 1'b0, 8'h1A, -1);
    expect_evt(3'd0, 1'b0, 8'h1D, -1);
    evt_bus.evt_ready = 1'b1;
    tick(10);
    check("bp_count_empty", int'(evt_bus.fifo_count), 0);
    drain("drain_bp");

    // Reset with three queued events and b[5] held through reset.
    evt_bus.evt_ready = 1'b0;
    tap(1);
    tap(2);
    b[5] = 1'b1;
    tick(10);
    check("rq_count", int'(evt_bus.fifo_count), 3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rq_valid", int'(evt_bus.evt_valid), 0);
    check("rq_count0", int'(evt_bus.fifo_count), 0);
    check("rq_overflow", int'(evt_bus.overflow), 0);
    evt_bus.evt_ready = 1'b1;
    tick(30);
    b[5] = 1'b0;
    tick(10);
    c0 = cyc;
    b[5] = 1'b1;
    expect_evt(3'd0, 1'b0, 8'h05, c0 + LAT);
    tick(10);
    b[5] = 1'b0;
    tick(20);
    drain("drain_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
